instr_fetch: RTL and testbench
==============================

# instr_fetch

Instruction fetch stage sitting directly upstream of the byte-addressed `memory` block. Generates sequential word addresses from a program counter, issues single-word reads (access_size 2'b00), and captures the big-endian word returned one cycle later. Presents each instruction with its PC to the decode stage through a valid/stall handshake, with branch redirect and a one-entry skid buffer.

## Interface
- `START_ADDR`, 32'h80020000: PC after reset; matches the memory base address.
- `ADDR_W`, 32: address and PC width.
- `DATA_W`, 32: instruction width.
- `clock` in 1: single clock; all state updates on rising edge.
- `reset_n` in 1: synchronous, active-low reset.
- `mem_address` out ADDR_W: read address to memory.
- `mem_access_size` out 2: constant 2'b00 (one word).
- `mem_rw` out 1: constant 1 (read).
- `mem_enable` out 1: read request this cycle.
- `mem_busy` in 1: memory busy; blocks issue.
- `mem_data_out` in DATA_W: read data, valid the cycle after a request.
- `stall` in 1: decode cannot accept; holds `insn`/`insn_pc`.
- `redirect` in 1: load new PC and flush.
- `redirect_pc` in ADDR_W: redirect target.
- `insn` out DATA_W: fetched instruction.
- `insn_pc` out ADDR_W: address of `insn`.
- `insn_valid` out 1: `insn`/`insn_pc` valid.
- `align_err` out 1: sticky misaligned-redirect flag (see Configuration).

## Operation
- States: IDLE (one cycle after reset), FETCH, HALT. IDLE→FETCH unconditionally; FETCH→HALT only on misaligned redirect with FETCH_ALIGN_CHK_EN; HALT exits only via reset.
- Registers: `pc` (next address to request), `req_pc`/`req_pending` (request in flight), skid entry (data, pc, valid), output regs.
- Issue: `mem_enable` = FETCH & !stall & !mem_busy & !skid_valid & !redirect; `mem_address` = `pc`. On issue: `req_pc`←`pc`, `req_pending`←1, `pc`←`pc`+4 (mod 2^32, wraps 0xFFFFFFFC→0).
- Response (cycle after issue, `req_pending`=1): if output empty or `stall`=0, load `mem_data_out`/`req_pc` into output, `insn_valid`←1; else load into skid.
- Consume: with `stall`=0 and `insn_valid`=1, output advances: from skid if `skid_valid`, else from response, else `insn_valid`←0.
- Stall: outputs hold stable; no new issue; at most one in-flight word, caught by skid. Skid never overflows.
- Redirect (priority over stall, response, issue): `pc`←`redirect_pc`, `req_pending`, skid valid and `insn_valid` cleared at that edge; in-flight data discarded. Issue resumes next cycle.
- `mem_busy` asserted: issue blocked only; pending response still captured.
- Reset: `pc`←START_ADDR, state IDLE; `insn_valid`, `req_pending`, skid valid, `align_err`, `mem_enable` = 0; `insn`, `insn_pc` = 0. Reset mid-request discards the response.

## Timing
- Reset released before edge 0; cycle 0 IDLE; cycle 1 first `mem_enable` with address START_ADDR; `insn_valid`=1 from cycle 2 edge onward.
- Request→`insn_valid` latency: 2 edges (issue edge, capture edge). Throughput 1 word/cycle without stall/busy.
- Stall released: skid word presented the next cycle; issue restarts same cycle `stall` drops (skid empty) or cycle after skid drains.
- Redirect at cycle N: first request to `redirect_pc` at N+1, its `insn_valid` at N+2 edge; `insn_valid`=0 during N+1.

## Configuration
- `FETCH_ALIGN_CHK_EN` defined: redirect with `redirect_pc[1:0]`≠0 sets `align_err`=1 (sticky), enters HALT, `mem_enable` held 0, `insn_valid` cleared.
- Not defined: `redirect_pc[1:0]` ignored (forced 2'b00); `align_err` tied 0; HALT unreachable.

## Structure
- Package `fetch_pkg`: START_ADDR, ACCESS_WORD (2'b00), state enum {IDLE, FETCH, HALT}.
- Sub-module `fetch_skid`: one-entry data+PC buffer with load/drain/flush.

## Test plan
- Reset, no stall, memory preloaded 0x11111111, 0x22222222 at 0x80020000/4 -> `mem_enable` cycle 1, `insn`=0x11111111/`insn_pc`=0x80020000 at cycle 2, 0x22222222/0x80020004 at cycle 3.
- `stall` high cycles 3-5 -> `insn`/`insn_pc` stable, no issue; after release, skid word then sequential words, none lost/duplicated.
- `redirect`=1, `redirect_pc`=0x80020040 with word in flight -> in-flight dropped, `insn_valid`=0 next cycle, then `insn_pc`=0x80020040.
- `redirect_pc`=0x80020042 with FETCH_ALIGN_CHK_EN -> `align_err`=1, `mem_enable`=0 until `reset_n` low; without macro -> fetches 0x80020040.
- `redirect_pc`=0xFFFFFFFC -> next `mem_address` 0x00000000; `mem_busy` pulses -> issue pauses, order preserved.

Source files
------------

// File: rtl/fetch_pkg.sv
// ============================================================================
// Module   : fetch_pkg
// Purpose  : Shared constants and state encoding for the instruction fetch stage.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package fetch_pkg;

    localparam logic [31:0] START_ADDR  = 32'h8002_0000;
    localparam logic [1:0]  ACCESS_WORD = 2'b00;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HALT  = 2'd2
    } fetch_state_t;

endpackage

`default_nettype wire

// File: rtl/fetch_skid.sv
// ============================================================================
// Module   : fetch_skid
// Purpose  : One-entry data+PC buffer catching the in-flight word during stall.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_skid
    import fetch_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              load,
    input  logic              drain,
    input  logic              flush,
    input  logic [DATA_W-1:0] load_data,
    input  logic [ADDR_W-1:0] load_pc,
    output logic [DATA_W-1:0] skid_data,
    output logic [ADDR_W-1:0] skid_pc,
    output logic              skid_valid
);

    logic [DATA_W-1:0] r_data;
    logic [ADDR_W-1:0] r_pc;
    logic              r_valid;

    // Flush wins over load so a redirect always discards in-flight data.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_data  <= '0;
            r_pc    <= '0;
            r_valid <= 1'b0;
        end else if (flush) begin
            r_valid <= 1'b0;
        end else if (load) begin
            r_data  <= load_data;
            r_pc    <= load_pc;
            r_valid <= 1'b1;
        end else if (drain) begin
            r_valid <= 1'b0;
        end
    end

    assign skid_data  = r_data;
    assign skid_pc    = r_pc;
    assign skid_valid = r_valid;

endmodule

`default_nettype wire

// File: rtl/instr_fetch.sv
// ============================================================================
// Module   : instr_fetch
// Purpose  : Sequential word fetch with valid/stall handshake, redirect and skid.
//            Optional macro FETCH_ALIGN_CHK_EN halts on misaligned redirects.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_fetch
    import fetch_pkg::*;
#(
    parameter int                ADDR_W     = 32,
    parameter int                DATA_W     = 32,
    parameter logic [ADDR_W-1:0] START_ADDR = fetch_pkg::START_ADDR
) (
    input  logic              clock,
    input  logic              reset_n,
    output logic [ADDR_W-1:0] mem_address,
    output logic [1:0]        mem_access_size,
    output logic              mem_rw,
    output logic              mem_enable,
    input  logic              mem_busy,
    input  logic [DATA_W-1:0] mem_data_out,
    input  logic              stall,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic [DATA_W-1:0] insn,
    output logic [ADDR_W-1:0] insn_pc,
    output logic              insn_valid,
    output logic              align_err
);

    fetch_state_t      r_state;
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] r_req_pc;
    logic              r_req_pending;
    logic [DATA_W-1:0] r_insn;
    logic [ADDR_W-1:0] r_insn_pc;
    logic              r_insn_valid;

    logic [DATA_W-1:0] w_skid_data;
    logic [ADDR_W-1:0] w_skid_pc;
    logic              w_skid_valid;
    logic              w_consume_ok;
    logic              w_skid_drain;
    logic              w_skid_load;
    logic              w_issue;
    logic [ADDR_W-1:0] w_redirect_target;

    // Output register may be (re)loaded when it is empty or decode takes it.
    assign w_consume_ok = !r_insn_valid || !stall;
    assign w_skid_drain = w_consume_ok && w_skid_valid;
    assign w_skid_load  = r_req_pending && (w_skid_drain || !w_consume_ok);

    assign w_issue = (r_state == FETCH) && !stall && !mem_busy
                     && !w_skid_valid && !redirect;

    assign w_redirect_target = {redirect_pc[ADDR_W-1:2], 2'b00};

`ifdef FETCH_ALIGN_CHK_EN
    logic r_align_err;
    logic w_misaligned;
    assign w_misaligned = (redirect_pc[1:0] != 2'b00);
    assign align_err    = r_align_err;
`else
    logic w_unused_low_bits;
    assign w_unused_low_bits = ^redirect_pc[1:0];
    assign align_err         = 1'b0;
`endif

    fetch_skid #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_skid (
        .clock      (clock),
        .reset_n    (reset_n),
        .load       (w_skid_load),
        .drain      (w_skid_drain),
        .flush      (redirect),
        .load_data  (mem_data_out),
        .load_pc    (r_req_pc),
        .skid_data  (w_skid_data),
        .skid_pc    (w_skid_pc),
        .skid_valid (w_skid_valid)
    );

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state       <= IDLE;
            r_pc          <= START_ADDR;
            r_req_pc      <= '0;
            r_req_pending <= 1'b0;
            r_insn        <= '0;
            r_insn_pc     <= '0;
            r_insn_valid  <= 1'b0;
`ifdef FETCH_ALIGN_CHK_EN
            r_align_err   <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE:    r_state <= FETCH;
                FETCH:   r_state <= FETCH;
                default: r_state <= HALT;
            endcase

            if (redirect && (r_state != HALT)) begin
                r_req_pending <= 1'b0;
                r_insn_valid  <= 1'b0;
`ifdef FETCH_ALIGN_CHK_EN
                if (w_misaligned) begin
                    r_state     <= HALT;
                    r_align_err <= 1'b1;
                end else begin
                    r_pc <= w_redirect_target;
                end
`else
                r_pc <= w_redirect_target;
`endif
            end else begin
                r_req_pending <= w_issue;
                if (w_issue) begin
                    r_req_pc <= r_pc;
                    r_pc     <= r_pc + ADDR_W'(4);
                end

                // Skid holds the older word, so it is presented before any response.
                if (w_consume_ok) begin
                    if (w_skid_valid) begin
                        r_insn       <= w_skid_data;
                        r_insn_pc    <= w_skid_pc;
                        r_insn_valid <= 1'b1;
                    end else if (r_req_pending) begin
                        r_insn       <= mem_data_out;
                        r_insn_pc    <= r_req_pc;
                        r_insn_valid <= 1'b1;
                    end else begin
                        r_insn_valid <= 1'b0;
                    end
                end
            end
        end
    end

    assign mem_address     = r_pc;
    assign mem_access_size = ACCESS_WORD;
    assign mem_rw          = 1'b1;
    assign mem_enable      = w_issue;
    assign insn            = r_insn;
    assign insn_pc         = r_insn_pc;
    assign insn_valid      = r_insn_valid;

endmodule

`default_nettype wire

// File: tb/tb_instr_fetch.sv
// ============================================================================
// Module   : tb_instr_fetch
// Purpose  : Self-checking bench for instr_fetch with a memory model and an
//            instruction-stream reference model (FETCH_ALIGN_CHK_EN aware).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_instr_fetch;

    localparam logic [31:0] BASE = 32'h8002_0000;

    logic        clock;
    logic        reset_n;
    logic [31:0] mem_address;
    logic [1:0]  mem_access_size;
    logic        mem_rw;
    logic        mem_enable;
    logic        mem_busy;
    logic [31:0] mem_data_out;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] insn;
    logic [31:0] insn_pc;
    logic        insn_valid;
    logic        align_err;

    int checks = 0;
    int errors = 0;

    instr_fetch dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .mem_address     (mem_address),
        .mem_access_size (mem_access_size),
        .mem_rw          (mem_rw),
        .mem_enable      (mem_enable),
        .mem_busy        (mem_busy),
        .mem_data_out    (mem_data_out),
        .stall           (stall),
        .redirect        (redirect),
        .redirect_pc     (redirect_pc),
        .insn            (insn),
        .insn_pc         (insn_pc),
        .insn_valid      (insn_valid),
        .align_err       (align_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == BASE)                return 32'h1111_1111;
        else if (a == BASE + 32'd4)   return 32'h2222_2222;
        else                          return (a * 32'h9E37_79B1) ^ 32'h5BD1_E995;
    endfunction

    // Memory answers one cycle after a request; garbage otherwise.
    always @(posedge clock) begin
        if (mem_enable) mem_data_out <= mem_word(mem_address);
        else            mem_data_out <= $urandom();
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; stall = 1'b0; mem_busy = 1'b0;
        redirect = 1'b0; redirect_pc = '0;
        repeat (3) tick();
        reset_n = 1'b1;
        @(negedge clock);
        checks++;
        if (mem_enable !== 1'b0) begin errors++; $display("FAIL reset_enable got=%b want=0", mem_enable); end
        checks++;
        if (insn_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b want=0", insn_valid); end
        checks++;
        if (insn !== 32'h0 || insn_pc !== 32'h0) begin
            errors++; $display("FAIL reset_insn got=%h/%h want=0/0", insn, insn_pc);
        end
        checks++;
        if (align_err !== 1'b0) begin errors++; $display("FAIL reset_align got=%b want=0", align_err); end
        checks++;
        if (mem_rw !== 1'b1 || mem_access_size !== 2'b00) begin
            errors++; $display("FAIL reset_const got rw=%b size=%b want 1/00", mem_rw, mem_access_size);
        end
    endtask

    task automatic test_first_fetch();
        tick(); @(negedge clock);
        checks++;
        if (mem_enable !== 1'b1 || mem_address !== BASE) begin
            errors++; $display("FAIL first_issue got en=%b addr=%h want 1/%h", mem_enable, mem_address, BASE);
        end
        tick(); @(negedge clock);
        checks++;
        if (insn_valid !== 1'b0 || mem_enable !== 1'b1 || mem_address !== BASE + 32'd4) begin
            errors++; $display("FAIL second_issue got v=%b en=%b addr=%h want 0/1/%h",
                               insn_valid, mem_enable, mem_address, BASE + 32'd4);
        end
        tick(); @(negedge clock);
        checks++;
        if (insn_valid !== 1'b1 || insn !== 32'h1111_1111 || insn_pc !== BASE) begin
            errors++; $display("FAIL first_insn got v=%b %h@%h want 1 11111111@%h", insn_valid, insn, insn_pc, BASE);
        end
        tick(); @(negedge clock);
        checks++;
        if (insn_valid !== 1'b1 || insn !== 32'h2222_2222 || insn_pc !== BASE + 32'd4) begin
            errors++; $display("FAIL second_insn got v=%b %h@%h want 1 22222222@%h",
                               insn_valid, insn, insn_pc, BASE + 32'd4);
        end
    endtask

    task automatic test_stall();
        logic [31:0] p;
        logic [31:0] exp_pc;
        int got;
        int budget;
        tick(); stall = 1'b1;
        @(negedge clock);
        p = insn_pc;
        checks++;
        if (insn_valid !== 1'b1 || insn_pc !== BASE + 32'd8 || insn !== mem_word(BASE + 32'd8)) begin
            errors++; $display("FAIL stall_entry got v=%b %h@%h want 1 %h@%h",
                               insn_valid, insn, insn_pc, mem_word(BASE + 32'd8), BASE + 32'd8);
        end
        for (int i = 0; i < 3; i++) begin
            if (i > 0) begin tick(); @(negedge clock); end
            checks++;
            if (insn_valid !== 1'b1 || insn_pc !== p || insn !== mem_word(p) || mem_enable !== 1'b0) begin
                errors++; $display("FAIL stall_hold cyc=%0d got v=%b %h@%h en=%b want 1 %h@%h en=0",
                                   i, insn_valid, insn, insn_pc, mem_enable, mem_word(p), p);
            end
        end
        tick(); stall = 1'b0;
        @(negedge clock);
        checks++;
        if (insn_valid !== 1'b1 || insn_pc !== p) begin
            errors++; $display("FAIL stall_release got v=%b pc=%h want 1/%h", insn_valid, insn_pc, p);
        end
        exp_pc = p + 32'd4;
        got = 0;
        budget = 0;
        while (got < 4 && budget < 30) begin
            tick(); @(negedge clock);
            budget++;
            if (insn_valid === 1'b1) begin
                checks++;
                if (insn_pc !== exp_pc || insn !== mem_word(exp_pc)) begin
                    errors++; $display("FAIL stall_drain got %h@%h want %h@%h", insn, insn_pc, mem_word(exp_pc), exp_pc);
                end
                exp_pc += 32'd4;
                got++;
            end
        end
        checks++;
        if (got < 4) begin errors++; $display("FAIL stall_timeout got=%0d words want=4", got); end
    endtask

    task automatic redirect_and_check(input logic [31:0] target, input logic [31:0] want_pc, input string name);
        tick(); redirect = 1'b1; redirect_pc = target;
        @(negedge clock);
        checks++;
        if (mem_enable !== 1'b0) begin errors++; $display("FAIL %s_gate got en=%b want=0", name, mem_enable); end
        tick(); redirect = 1'b0;
        @(negedge clock);
        checks++;
        if (insn_valid !== 1'b0 || mem_enable !== 1'b1 || mem_address !== want_pc) begin
            errors++; $display("FAIL %s_issue got v=%b en=%b addr=%h want 0/1/%h",
                               name, insn_valid, mem_enable, mem_address, want_pc);
        end
        tick(); @(negedge clock);
        checks++;
        if (insn_valid !== 1'b0 || mem_address !== want_pc + 32'd4) begin
            errors++; $display("FAIL %s_bubble got v=%b addr=%h want 0/%h", name, insn_valid, mem_address, want_pc + 32'd4);
        end
        tick(); @(negedge clock);
        checks++;
        if (insn_valid !== 1'b1 || insn_pc !== want_pc || insn !== mem_word(want_pc)) begin
            errors++; $display("FAIL %s_insn got v=%b %h@%h want 1 %h@%h",
                               name, insn_valid, insn, insn_pc, mem_word(want_pc), want_pc);
        end
        tick(); @(negedge clock);
        checks++;
        if (insn_valid !== 1'b1 || insn_pc !== want_pc + 32'd4) begin
            errors++; $display("FAIL %s_next got v=%b pc=%h want 1/%h", name, insn_valid, insn_pc, want_pc + 32'd4);
        end
    endtask

    task automatic test_redirect();
        repeat (2) tick();
        redirect_and_check(32'h8002_0040, 32'h8002_0040, "redirect");
    endtask

    task automatic test_wrap();
        redirect_and_check(32'hFFFF_FFFC, 32'hFFFF_FFFC, "wrap");
    endtask

    task automatic test_random();
        logic [31:0] exp_issue, exp_cons, hold_pc, hold_insn, tgt;
        logic prev_hold, prev_redir;
        int consumed;
        exp_issue = '0; exp_cons = '0; hold_pc = '0; hold_insn = '0;
        prev_hold = 1'b0; prev_redir = 1'b0; consumed = 0;
        for (int i = 0; i < 4000; i++) begin
            tick();
            stall    = ($urandom_range(0, 99) < 30);
            mem_busy = ($urandom_range(0, 99) < 20);
            redirect = (i == 0) || ($urandom_range(0, 99) < 3);
            if ($urandom_range(0, 9) == 0) tgt = 32'hFFFF_FFF0 + 32'($urandom_range(0, 3)) * 32'd4;
            else                           tgt = BASE + 32'($urandom_range(0, 255)) * 32'd4;
`ifndef FETCH_ALIGN_CHK_EN
            tgt = tgt + 32'($urandom_range(0, 3));
`endif
            redirect_pc = tgt;
            @(negedge clock);
            checks++;
            if (mem_enable === 1'b1 && (stall || mem_busy || redirect)) begin
                errors++; $display("FAIL rnd_gate cyc=%0d en=1 stall=%b busy=%b redir=%b want en=0",
                                   i, stall, mem_busy, redirect);
            end
            if (mem_enable === 1'b1) begin
                checks++;
                if (mem_address !== exp_issue) begin
                    errors++; $display("FAIL rnd_addr cyc=%0d got=%h want=%h", i, mem_address, exp_issue);
                end
                exp_issue += 32'd4;
            end
            if (prev_hold) begin
                checks++;
                if (insn_valid !== 1'b1 || insn_pc !== hold_pc || insn !== hold_insn) begin
                    errors++; $display("FAIL rnd_hold cyc=%0d got v=%b %h@%h want 1 %h@%h",
                                       i, insn_valid, insn, insn_pc, hold_insn, hold_pc);
                end
            end
            if (prev_redir) begin
                checks++;
                if (insn_valid !== 1'b0) begin
                    errors++; $display("FAIL rnd_flush cyc=%0d got v=%b want=0", i, insn_valid);
                end
            end
            if (insn_valid === 1'b1 && i > 0) begin
                checks++;
                if (insn !== mem_word(insn_pc)) begin
                    errors++; $display("FAIL rnd_data cyc=%0d got=%h want=%h", i, insn, mem_word(insn_pc));
                end
                if (!stall) begin
                    checks++;
                    if (insn_pc !== exp_cons) begin
                        errors++; $display("FAIL rnd_order cyc=%0d got=%h want=%h", i, insn_pc, exp_cons);
                    end
                    exp_cons += 32'd4;
                    consumed++;
                end
            end
            prev_hold  = stall && (insn_valid === 1'b1) && !redirect;
            hold_pc    = insn_pc;
            hold_insn  = insn;
            prev_redir = redirect;
            if (redirect) begin
                exp_issue = {tgt[31:2], 2'b00};
                exp_cons  = {tgt[31:2], 2'b00};
            end
        end
        tick(); stall = 1'b0; mem_busy = 1'b0; redirect = 1'b0;
        checks++;
        if (consumed < 400) begin errors++; $display("FAIL rnd_progress got=%0d words want>=400", consumed); end
    endtask

    task automatic test_misaligned();
`ifdef FETCH_ALIGN_CHK_EN
        tick(); redirect = 1'b1; redirect_pc = 32'h8002_0042;
        tick(); redirect = 1'b1; redirect_pc = 32'h8002_0080;
        tick(); redirect = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            checks++;
            if (align_err !== 1'b1 || mem_enable !== 1'b0 || insn_valid !== 1'b0) begin
                errors++; $display("FAIL misalign_halt cyc=%0d got err=%b en=%b v=%b want 1/0/0",
                                   i, align_err, mem_enable, insn_valid);
            end
            tick();
        end
`else
        redirect_and_check(32'h8002_0042, 32'h8002_0040, "misalign");
        checks++;
        if (align_err !== 1'b0) begin errors++; $display("FAIL misalign_err got=%b want=0", align_err); end
`endif
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_first_fetch();
        test_stall();
        test_redirect();
        test_wrap();
        test_random();
        test_misaligned();
        test_reset();
        test_first_fetch();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
